// File: rtl/axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_arbiter
// Description : Round-robin AXI write-path arbiter (AW/W/B), NUM_MST masters to
//               one slave. Optional WLAST/AWLEN check via AXI_WR_ARB_LEN_CHECK_EN.
// Revision    : 1.0  initial release
// ============================================================================
module axi_wr_arbiter #(
    parameter int NUM_MST    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MW         = $clog2(NUM_MST)
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic [NUM_MST*ID_WIDTH-1:0]        M_AWID,
    input  logic [NUM_MST*ADDR_WIDTH-1:0]      M_AWADDR,
    input  logic [NUM_MST*8-1:0]               M_AWLEN,
    input  logic [NUM_MST*3-1:0]               M_AWSIZE,
    input  logic [NUM_MST*2-1:0]               M_AWBURST,
    input  logic [NUM_MST*3-1:0]               M_AWPROT,
    input  logic [NUM_MST-1:0]                 M_AWVALID,
    output logic [NUM_MST-1:0]                 M_AWREADY,
    input  logic [NUM_MST*DATA_WIDTH-1:0]      M_WDATA,
    input  logic [NUM_MST*(DATA_WIDTH/8)-1:0]  M_WSTRB,
    input  logic [NUM_MST-1:0]                 M_WLAST,
    input  logic [NUM_MST-1:0]                 M_WVALID,
    output logic [NUM_MST-1:0]                 M_WREADY,
    output logic [NUM_MST*ID_WIDTH-1:0]        M_BID,
    output logic [NUM_MST*2-1:0]               M_BRESP,
    output logic [NUM_MST-1:0]                 M_BVALID,
    input  logic [NUM_MST-1:0]                 M_BREADY,
    output logic [ID_WIDTH+MW-1:0]             S_AWID,
    output logic [ADDR_WIDTH-1:0]              S_AWADDR,
    output logic [7:0]                         S_AWLEN,
    output logic [2:0]                         S_AWSIZE,
    output logic [1:0]                         S_AWBURST,
    output logic [2:0]                         S_AWPROT,
    output logic                               S_AWVALID,
    input  logic                               S_AWREADY,
    output logic [ID_WIDTH+MW-1:0]             S_WID,
    output logic [DATA_WIDTH-1:0]              S_WDATA,
    output logic [DATA_WIDTH/8-1:0]            S_WSTRB,
    output logic                               S_WLAST,
    output logic                               S_WVALID,
    input  logic                               S_WREADY,
    input  logic [ID_WIDTH+MW-1:0]             S_BID,
    input  logic [1:0]                         S_BRESP,
    input  logic                               S_BVALID,
    output logic                               S_BREADY,
    output logic                               ERR_WLAST
);

    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [MW-1:0]         grant_q, grant_d;
    logic [MW-1:0]         last_q, last_d;
    logic [ID_WIDTH-1:0]   awid_q;
    logic [7:0]            beat_cnt_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  rr_found;
    logic [MW-1:0]         rr_idx;
    logic [MW-1:0]         b_sel;
    logic                  b_sel_ok;

    // Scan from farthest to nearest so the nearest requester after last_q wins.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = NUM_MST; k >= 1; k--) begin
            if (M_AWVALID[(int'(last_q) + k) % NUM_MST]) begin
                rr_found = 1'b1;
                rr_idx   = MW'((int'(last_q) + k) % NUM_MST);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d = rr_idx;
                    last_d  = rr_idx;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (aw_hs) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs && S_WLAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        S_AWID    = '0;
        S_AWADDR  = '0;
        S_AWLEN   = '0;
        S_AWSIZE  = '0;
        S_AWBURST = '0;
        S_AWPROT  = '0;
        S_AWVALID = 1'b0;
        M_AWREADY = '0;
        S_WID     = '0;
        S_WDATA   = '0;
        S_WSTRB   = '0;
        S_WLAST   = 1'b0;
        S_WVALID  = 1'b0;
        M_WREADY  = '0;
        if (state_q == ST_ADDR) begin
            S_AWID             = {grant_q, M_AWID[grant_q*ID_WIDTH +: ID_WIDTH]};
            S_AWADDR           = M_AWADDR[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
            S_AWLEN            = M_AWLEN[grant_q*8 +: 8];
            S_AWSIZE           = M_AWSIZE[grant_q*3 +: 3];
            S_AWBURST          = M_AWBURST[grant_q*2 +: 2];
            S_AWPROT           = M_AWPROT[grant_q*3 +: 3];
            S_AWVALID          = M_AWVALID[grant_q];
            M_AWREADY[grant_q] = S_AWREADY;
        end
        if (state_q == ST_DATA) begin
            S_WID             = {grant_q, awid_q};
            S_WDATA           = M_WDATA[grant_q*DATA_WIDTH +: DATA_WIDTH];
            S_WSTRB           = M_WSTRB[grant_q*STRB_W +: STRB_W];
            S_WLAST           = M_WLAST[grant_q];
            S_WVALID          = M_WVALID[grant_q];
            M_WREADY[grant_q] = S_WREADY;
        end
    end

    assign aw_hs = S_AWVALID & S_AWREADY;
    assign w_hs  = S_WVALID & S_WREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_q     <= MW'(NUM_MST - 1);
            awid_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            if (aw_hs) begin
                awid_q <= S_AWID[ID_WIDTH-1:0];
            end
            if (w_hs) begin
                if (S_WLAST) begin
                    beat_cnt_q <= '0;
                end else if (beat_cnt_q != 8'hFF) begin
                    beat_cnt_q <= beat_cnt_q + 8'd1;
                end
            end
        end
    end

    // B channel is purely combinational and independent of the AW/W state.
    assign b_sel    = S_BID[ID_WIDTH+MW-1:ID_WIDTH];
    assign b_sel_ok = (int'(b_sel) < NUM_MST);
    assign M_BID    = {NUM_MST{S_BID[ID_WIDTH-1:0]}};
    assign M_BRESP  = {NUM_MST{S_BRESP}};

    always_comb begin
        M_BVALID = '0;
        S_BREADY = 1'b1;
        if (b_sel_ok) begin
            M_BVALID[b_sel] = S_BVALID;
            S_BREADY        = M_BREADY[b_sel];
        end
    end

`ifdef AXI_WR_ARB_LEN_CHECK_EN
    logic [7:0] awlen_q;
    logic       err_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awlen_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (aw_hs) begin
                awlen_q <= S_AWLEN;
            end
            err_q <= w_hs && ((beat_cnt_q == awlen_q) != S_WLAST);
        end
    end

    assign ERR_WLAST = err_q;
`else
    assign ERR_WLAST = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_arbiter.sv
`default_nettype none
// Testbench for axi_wr_arbiter: randomized masters/slave against a transaction-level
// round-robin and scoreboard model.
module tb_axi_wr_arbiter;
    localparam int N = 4, AW = 32, DW = 32, IW = 4, MW = 2, SW = DW / 8, MAXB = 4;

    logic ACLK = 1'b0;
    logic ARESET;
    logic [N*IW-1:0] M_AWID;
    logic [N*AW-1:0] M_AWADDR;
    logic [N*8-1:0]  M_AWLEN;
    logic [N*3-1:0]  M_AWSIZE;
    logic [N*2-1:0]  M_AWBURST;
    logic [N*3-1:0]  M_AWPROT;
    logic [N-1:0]    M_AWVALID, M_AWREADY;
    logic [N*DW-1:0] M_WDATA;
    logic [N*SW-1:0] M_WSTRB;
    logic [N-1:0]    M_WLAST, M_WVALID, M_WREADY;
    logic [N*IW-1:0] M_BID;
    logic [N*2-1:0]  M_BRESP;
    logic [N-1:0]    M_BVALID, M_BREADY;
    logic [IW+MW-1:0] S_AWID, S_WID, S_BID;
    logic [AW-1:0]   S_AWADDR;
    logic [7:0]      S_AWLEN;
    logic [2:0]      S_AWSIZE, S_AWPROT;
    logic [1:0]      S_AWBURST, S_BRESP;
    logic            S_AWVALID, S_AWREADY, S_WLAST, S_WVALID, S_WREADY;
    logic [DW-1:0]   S_WDATA;
    logic [SW-1:0]   S_WSTRB;
    logic            S_BVALID, S_BREADY, ERR_WLAST;

    always #5 ACLK = ~ACLK;

    axi_wr_arbiter #(.NUM_MST(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MW(MW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
        .M_AWBURST(M_AWBURST), .M_AWPROT(M_AWPROT), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
        .M_WREADY(M_WREADY), .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID),
        .M_BREADY(M_BREADY), .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN),
        .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST), .S_AWPROT(S_AWPROT), .S_AWVALID(S_AWVALID),
        .S_AWREADY(S_AWREADY), .S_WID(S_WID), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
        .S_WLAST(S_WLAST), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_BID(S_BID),
        .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .ERR_WLAST(ERR_WLAST)
    );

    // Per-master burst lists; a master requests AW for every burst not yet accepted
    // and streams W beats of its bursts strictly in order.
    int              n_b[N], aw_k[N], w_k[N], w_beat[N];
    logic [IW-1:0]   b_id[N][MAXB];
    logic [AW-1:0]   b_addr[N][MAXB];
    logic [7:0]      b_len[N][MAXB];
    logic [7:0]      b_attr[N][MAXB];
    logic [31:0]     b_seed[N][MAXB];
    int              b_lastb[N][MAXB];

    int   last_g, cur_m, cur_k, cur_beat;
    bit   in_burst, err_pend, quiet_b, seen_awv;
    int   w_vprob, cyc_since_load, first_awv;
    int   glog[$];
    logic [N-1:0] aw_hs_r, w_hs_r;
    int   checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int m, input int k, input int b);
        return b_seed[m][k] ^ (32'(b) * 32'h9E3779B9) ^ 32'(m);
    endfunction

    // Next master after 'last' (cyclic) that still has an unaccepted AW.
    function automatic int rr_pick(input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (aw_k[i] < n_b[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit all_done();
        for (int m = 0; m < N; m++) if (w_k[m] < n_b[m]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic load(input int m, input int len, input int lastb);
        int k;
        k = n_b[m];
        b_id[m][k]    = IW'($urandom);
        b_addr[m][k]  = $urandom;
        b_len[m][k]   = 8'(len);
        b_attr[m][k]  = 8'($urandom);
        b_seed[m][k]  = $urandom;
        b_lastb[m][k] = lastb;
        n_b[m]        = k + 1;
    endtask

    task automatic clear_masters();
        for (int m = 0; m < N; m++) begin
            n_b[m] = 0; aw_k[m] = 0; w_k[m] = 0; w_beat[m] = 0;
        end
    endtask

    task automatic drive();
        for (int m = 0; m < N; m++) begin
            logic [DW-1:0] d;
            if (aw_k[m] < n_b[m]) begin
                M_AWVALID[m]          = 1'b1;
                M_AWID[m*IW +: IW]    = b_id[m][aw_k[m]];
                M_AWADDR[m*AW +: AW]  = b_addr[m][aw_k[m]];
                M_AWLEN[m*8 +: 8]     = b_len[m][aw_k[m]];
                M_AWSIZE[m*3 +: 3]    = b_attr[m][aw_k[m]][2:0];
                M_AWBURST[m*2 +: 2]   = b_attr[m][aw_k[m]][4:3];
                M_AWPROT[m*3 +: 3]    = b_attr[m][aw_k[m]][7:5];
            end else begin
                M_AWVALID[m] = 1'b0;
            end
            if (w_k[m] < n_b[m]) begin
                d                    = beat_data(m, w_k[m], w_beat[m]);
                M_WVALID[m]          = ($urandom_range(99) < w_vprob);
                M_WDATA[m*DW +: DW]  = d;
                M_WSTRB[m*SW +: SW]  = d[SW-1:0];
                M_WLAST[m]           = (w_beat[m] == b_lastb[m][w_k[m]]);
            end else begin
                M_WVALID[m] = 1'b0;
                M_WLAST[m]  = 1'b0;
            end
        end
        S_AWREADY = ($urandom_range(99) < 70);
        S_WREADY  = ($urandom_range(99) < 75);
        S_BID     = (IW+MW)'($urandom);
        S_BRESP   = 2'($urandom);
        S_BVALID  = quiet_b ? 1'b0 : 1'($urandom);
        M_BREADY  = N'($urandom);
    endtask

    task automatic monitor();
        int sel, g, k;
        bit busy0, lastbeat;
        logic [N-1:0] e;
        logic [DW-1:0] d;
        aw_hs_r = M_AWVALID & M_AWREADY;
        w_hs_r  = M_WVALID & M_WREADY;
        busy0   = in_burst;
        // B routing by ID prefix, payload broadcast.
        sel = int'(S_BID[IW+MW-1:IW]);
        e = '0;
        if (S_BVALID && sel < N) e[sel] = 1'b1;
        chk("m_bvalid", M_BVALID, e);
        chk("s_bready", S_BREADY, (sel < N) ? M_BREADY[sel] : 1'b1);
        chk("m_bid", M_BID, {N{S_BID[IW-1:0]}});
        chk("m_bresp", M_BRESP, {N{S_BRESP}});
        chk("err_wlast", ERR_WLAST, err_pend);
        err_pend = 1'b0;
        // W path belongs only to the master whose AW was last accepted.
        e = '0;
        if (in_burst) e[cur_m] = S_WREADY;
        chk("m_wready", M_WREADY, e);
        chk("s_wvalid", S_WVALID, in_burst ? M_WVALID[cur_m] : 1'b0);
        if (in_burst && S_WVALID && S_WREADY) begin
            d        = beat_data(cur_m, cur_k, cur_beat);
            lastbeat = (cur_beat == b_lastb[cur_m][cur_k]);
            chk("s_wid", S_WID, {cur_m[MW-1:0], b_id[cur_m][cur_k]});
            chk("s_wdata", S_WDATA, d);
            chk("s_wstrb", S_WSTRB, d[SW-1:0]);
            chk("s_wlast", S_WLAST, lastbeat);
`ifdef AXI_WR_ARB_LEN_CHECK_EN
            err_pend = ((cur_beat == int'(b_len[cur_m][cur_k])) != lastbeat);
`endif
            if (lastbeat) in_burst = 1'b0;
            else cur_beat++;
        end
        // AW path
        if (busy0) begin
            chk("s_awvalid_busy", S_AWVALID, 1'b0);
        end else if (S_AWVALID) begin
            g = rr_pick(last_g);
            chk("aw_grant_exists", 64'(g >= 0), 1);
            if (g >= 0) begin
                k = aw_k[g];
                chk("s_awid", S_AWID, {g[MW-1:0], b_id[g][k]});
                chk("s_awaddr", S_AWADDR, b_addr[g][k]);
                chk("s_awlen", S_AWLEN, b_len[g][k]);
                chk("s_awattr", {S_AWPROT, S_AWBURST, S_AWSIZE}, b_attr[g][k]);
                e = '0;
                e[g] = S_AWREADY;
                chk("m_awready", M_AWREADY, e);
                if (S_AWREADY) begin
                    last_g = g; in_burst = 1'b1; cur_m = g; cur_k = k; cur_beat = 0;
                    glog.push_back(g);
                end
            end
        end else begin
            chk("m_awready_idle", M_AWREADY, '0);
        end
        if (!seen_awv && S_AWVALID) begin
            seen_awv  = 1'b1;
            first_awv = cyc_since_load;
        end
        cyc_since_load++;
    endtask

    task automatic update();
        for (int m = 0; m < N; m++) begin
            if (aw_hs_r[m]) aw_k[m]++;
            if (w_hs_r[m]) begin
                if (w_beat[m] == b_lastb[m][w_k[m]]) begin
                    w_k[m]++; w_beat[m] = 0;
                end else begin
                    w_beat[m]++;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge ACLK);
        monitor();
        @(posedge ACLK);
        #1;
        update();
        drive();
    endtask

    task automatic run_round(input int budget);
        int cyc;
        cyc = 0;
        glog.delete();
        seen_awv = 1'b0; cyc_since_load = 0; first_awv = -1;
        drive();
        while (!all_done() && cyc < budget) begin
            step();
            cyc++;
        end
        chk("round_done", all_done(), 1'b1);
        chk("aw_latency", 64'(first_awv), 1);
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, "_s_awvalid"}, S_AWVALID, 1'b0);
        chk({tag, "_s_wvalid"}, S_WVALID, 1'b0);
        chk({tag, "_m_awready"}, M_AWREADY, '0);
        chk({tag, "_m_wready"}, M_WREADY, '0);
        chk({tag, "_m_bvalid"}, M_BVALID, '0);
        chk({tag, "_err"}, ERR_WLAST, 1'b0);
    endtask

    initial begin
        int cnt;
        ARESET = 1'b1; quiet_b = 1'b1; w_vprob = 80;
        in_burst = 1'b0; err_pend = 1'b0; last_g = N - 1;
        M_AWID = '0; M_AWADDR = '0; M_AWLEN = '0; M_AWSIZE = '0; M_AWBURST = '0;
        M_AWPROT = '0; M_WDATA = '0; M_WSTRB = '0; M_WLAST = '0;
        clear_masters();
        drive();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        zero_outputs("reset");
        @(posedge ACLK);
        #1;
        ARESET = 1'b0; quiet_b = 1'b0;

        // All four masters request together: round-robin from master 0.
        for (int m = 0; m < N; m++) load(m, 0, 0);
        run_round(500);
        chk("rrA_count", 64'(glog.size()), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("rrA_order", 64'(glog[i]), 64'(i));

        // Two continuous requesters alternate.
        clear_masters();
        for (int j = 0; j < 2; j++) begin load(1, 3, 3); load(2, 3, 3); end
        run_round(1000);
        chk("rrB_count", 64'(glog.size()), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("rrB_order", 64'(glog[i]), (i % 2 == 0) ? 1 : 2);

        // W data offered before AW.
        clear_masters();
        w_vprob = 100;
        load(0, 5, 5);
        run_round(500);
        w_vprob = 80;

        // Randomized rounds.
        for (int r = 0; r < 12; r++) begin
            clear_masters();
            for (int m = 0; m < N; m++) begin
                if ($urandom_range(1) == 1) begin
                    cnt = $urandom_range(1, 3);
                    for (int j = 0; j < cnt; j++) begin
                        int len;
                        len = $urandom_range(0, 7);
                        load(m, len, len);
                    end
                end
            end
            if (n_b[0] + n_b[1] + n_b[2] + n_b[3] == 0) load($urandom_range(N - 1), 2, 2);
            run_round(3000);
        end

        // Early WLAST on beat 2 of an AWLEN=3 burst.
        clear_masters();
        load(2, 3, 2);
        run_round(500);
        step();

        // Reset in the middle of a burst, after two beats.
        clear_masters();
        w_vprob = 100;
        load(3, 3, 3);
        glog.delete();
        drive();
        cnt = 0;
        while (!(w_k[3] == 0 && w_beat[3] == 2) && cnt < 200) begin
            step();
            cnt++;
        end
        chk("midburst_reached", 64'(w_beat[3]), 2);
        ARESET = 1'b1; quiet_b = 1'b1;
        clear_masters();
        drive();
        @(negedge ACLK);
        monitor();
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        in_burst = 1'b0; last_g = N - 1; err_pend = 1'b0;
        drive();
        @(negedge ACLK);
        zero_outputs("post_reset");
        monitor();
        @(posedge ACLK);
        #1;
        quiet_b = 1'b0; w_vprob = 80;
        for (int m = 0; m < N; m++) load(m, 1, 1);
        run_round(800);
        chk("first_grant_after_reset", (glog.size() > 0) ? 64'(glog[0]) : 64'hFFFF, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
